// File: rtl/sar_compare_ctrl_pkg.sv
// Shared types for the SAR compare controller.
// SAR_SAMPLE is only reached when SAR_SETTLE_EN is defined.
package sar_compare_ctrl_pkg;

  localparam int SAR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    SAR_IDLE   = 2'd0,
    SAR_SEARCH = 2'd1,
    SAR_DONE   = 2'd2,
    SAR_SAMPLE = 2'd3
  } sar_state_t;

endpackage

// File: rtl/sar_compare_ctrl_mask_shifter.sv
// One-hot bit pointer for the SAR search.
// mask is 1<<k; last flags the pointer at bit 0.
module sar_mask_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  output logic [WIDTH-1:0] mask,
  output logic             last
);

  localparam logic [WIDTH-1:0] TOP = {1'b1, {(WIDTH-1){1'b0}}};

  // Pointer parks at bit 0 instead of wrapping; load restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= TOP;
    end else if (load) begin
      mask <= TOP;
    end else if (shift && !last) begin
      mask <= mask >> 1;
    end
  end

  assign last = mask[0];

endmodule

// File: rtl/sar_compare_ctrl.sv
// Successive-approximation controller driving DataB of a comparator.
// Define SAR_SETTLE_EN for two-cycle (set/sample) trials.
module sar_compare_ctrl
  import sar_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             AGEB,
  output logic [WIDTH-1:0] DataB,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  sar_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] trial;
  logic             last;
  logic             load;
  logic             decide;

  assign trial = acc | mask;
  assign load  = (state == SAR_IDLE) && start;

`ifdef SAR_SETTLE_EN
  assign decide = (state == SAR_SAMPLE);
`else
  assign decide = (state == SAR_SEARCH);
`endif

  sar_mask_shifter #(
    .WIDTH(WIDTH)
  ) u_mask (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .shift(decide),
    .mask (mask),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SAR_IDLE;
      acc    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        SAR_IDLE: begin
          if (start) begin
            state <= SAR_SEARCH;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
`ifdef SAR_SETTLE_EN
        SAR_SEARCH: begin
          state <= SAR_SAMPLE;
        end
        SAR_SAMPLE: begin
          if (AGEB) acc <= trial;
          if (last) begin
            state  <= SAR_DONE;
            done   <= 1'b1;
            result <= AGEB ? trial : acc;
          end else begin
            state <= SAR_SEARCH;
          end
        end
`else
        SAR_SEARCH: begin
          if (AGEB) acc <= trial;
          if (last) begin
            state  <= SAR_DONE;
            done   <= 1'b1;
            result <= AGEB ? trial : acc;
          end
        end
`endif
        SAR_DONE: begin
          state <= SAR_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= SAR_IDLE;
        end
      endcase
    end
  end

  // Decoded from registered state only, so AGEB never loops back.
  always_comb begin
    DataB = result;
    unique case (state)
      SAR_SEARCH: DataB = trial;
      SAR_SAMPLE: DataB = trial;
      SAR_DONE:   DataB = acc;
      default:    DataB = result;
    endcase
  end

endmodule

// File: tb/tb_sar_compare_ctrl.sv
// Bench for sar_compare_ctrl with a behavioural comparator.
// Define SAR_SETTLE_EN to check the two-cycle trial build.
module tb_sar_compare_ctrl;

  localparam int W = 8;
`ifdef SAR_SETTLE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int N   = W * STEP;
  localparam int LIM = 4 * N + 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_a = '0;
  logic         ageb;
  logic [W-1:0] data_b;
  logic [W-1:0] result;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ageb = (data_a >= data_b);

  sar_compare_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .AGEB  (ageb),
    .DataB (data_b),
    .result(result),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Trial i keeps the top i bits of a and tests the next bit down.
  function automatic int trial_of(input int a, input int i);
    int keep;
    keep = W - i;
    return ((a >> keep) << keep) | (1 << (keep - 1));
  endfunction

  task automatic convert(input int a);
    @(negedge clk);
    data_a = W'(a);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      for (int s = 0; s < STEP; s++) begin
        chk("trial", 32'(data_b), 32'(trial_of(a, i)));
        chk("busy", 32'(busy), 1);
        chk("done_early", 32'(done), 0);
        @(negedge clk);
      end
    end
    chk("done", 32'(done), 1);
    chk("result", 32'(result), 32'(a));
    chk("done_busy", 32'(busy), 1);
    @(negedge clk);
    chk("done_width", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_datab", 32'(data_b), 32'(a));
  endtask

  initial begin
    int t;
    int ndone;
    int a;
    logic [W-1:0] last_res;

    #2;
    chk("rst_datab", 32'(data_b), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    convert(8'b0001_1001);
    convert(0);
    convert(255);

    // start re-asserted mid-search must not queue a second run
    @(negedge clk);
    data_a = 8'hB3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    last_res = '0;
    for (int c = 0; c < 2 * N + 10; c++) begin
      if (done) begin
        ndone++;
        last_res = result;
      end
      @(negedge clk);
    end
    chk("held_pulses", 32'(ndone), 1);
    chk("held_result", 32'(last_res), 32'hB3);
    chk("held_idle", 32'(busy), 0);

    // start held high: one IDLE cycle between conversions
    data_a = W'($urandom_range(0, 255));
    start  = 1'b1;
    t = 0;
    while (!done && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("hold_first_done", 32'(done), 1);
    @(negedge clk);
    chk("hold_gap_idle", 32'(busy), 0);
    t = 1;
    while (!done && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("hold_period", 32'(t), 32'(N + 2));
    chk("hold_result", 32'(result), 32'(data_a));
    start = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of a search
    data_a = 8'hF4;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_datab", 32'(data_b), 0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 0);
    rst_n = 1'b1;
    convert(8'hF4);

    // DataA moving mid-conversion still finishes on time
    @(negedge clk);
    data_a = W'($urandom_range(0, 255));
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 1;
    while (!done && t < LIM) begin
      @(negedge clk);
      t++;
      if (t == 3) data_a = W'($urandom_range(0, 255));
    end
    chk("move_latency", 32'(t), 32'(N + 1));
    @(negedge clk);

    for (int v = 0; v < 256; v++) convert(v);

    for (int r = 0; r < 20; r++) begin
      a = int'($urandom_range(0, 255));
      convert(a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
